sfifo36k_push_arbiter: RTL and testbench

- Write-side controller for the 36K synchronous FIFO block (SFIFO_36K_BLK).
- Shares the single FIFO push port between two streaming requesters using round-robin arbitration with a burst cap.
- Gates pushes on FIFO Full.
- Sequences FIFO flush and recovery on software request or on an Overrun_Error report from the FIFO.

---
 rtl/sfifo36k_push_arbiter.sv | 144 ++++++++++++++
 tb/tb_sfifo36k_push_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo36k_push_arbiter.sv
// Write-side controller for SFIFO_36K_BLK: round-robin push arbitration between two
// streaming requesters with a burst cap, Full gating, and flush/recovery sequencing.
module sfifo36k_push_arbiter #(
  parameter int WR_DATA_WIDTH = 18,
  parameter int MAX_BURST     = 8,
  parameter int FLUSH_CYCLES  = 4
) (
  input  logic                     clock0,
  input  logic                     reset_n,
  input  logic                     req0_valid,
  input  logic [WR_DATA_WIDTH-1:0] req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [WR_DATA_WIDTH-1:0] req1_data,
  output logic                     req1_ready,
  input  logic                     sw_flush,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  input  logic                     fifo_overrun,
  output logic [WR_DATA_WIDTH-1:0] fifo_din,
  output logic                     fifo_push,
  output logic                     fifo_async_flush,
  output logic                     owner,
  output logic                     flushing,
  output logic [7:0]               overrun_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    WAIT_EMPTY = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] overrun_cnt_q, overrun_cnt_d;

  logic       own_valid, oth_valid;
  logic       grant, sel, accept;

  // Arbitration is purely combinational from the registered owner/run_cnt so a
  // switch between requesters costs no bubble cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant     = 1'b0;
    sel       = owner_q;
    own_valid = owner_q ? req1_valid : req0_valid;
    oth_valid = owner_q ? req0_valid : req1_valid;
    // reset_n is folded in so no handshake is offered while reset is held.
    if (state_q == RUN && reset_n) begin
      if (own_valid && (run_cnt_q < 8'(MAX_BURST) || !oth_valid)) begin
        grant = 1'b1;
        sel   = owner_q;
      end else if (oth_valid) begin
        grant = 1'b1;
        sel   = ~owner_q;
      end
    end
    accept     = grant & ~fifo_full;
    req0_ready = accept & ~sel;
    req1_ready = accept & sel;
    fifo_push  = accept;
    fifo_din   = grant ? (sel ? req1_data : req0_data) : '0;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    run_cnt_d     = run_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    overrun_cnt_d = overrun_cnt_q;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (sel == owner_q) begin
            run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
          end else begin
            owner_d   = sel;
            run_cnt_d = 8'd1;
          end
        end
        // The transfer of this cycle has already completed; flush entry overrides
        // the arbitration bookkeeping.
        if (sw_flush || fifo_overrun) begin
          state_d     = FLUSH;
          flush_cnt_d = 4'd1;
          owner_d     = 1'b0;
          run_cnt_d   = 8'd0;
          if (fifo_overrun && overrun_cnt_q != 8'hFF) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
          end
        end
      end
      FLUSH: begin
        if (sw_flush) begin
          flush_cnt_d = 4'd1;
        end else if (flush_cnt_q == 4'(FLUSH_CYCLES)) begin
          state_d     = WAIT_EMPTY;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      WAIT_EMPTY: begin
        if (sw_flush) begin
          state_d     = FLUSH;
          flush_cnt_d = 4'd1;
          owner_d     = 1'b0;
          run_cnt_d   = 8'd0;
        end else if (fifo_empty) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      owner_q       <= 1'b0;
      run_cnt_q     <= 8'd0;
      flush_cnt_q   <= 4'd0;
      overrun_cnt_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value.
      state_q       <= state_d;
      owner_q       <= owner_d;
      run_cnt_q     <= run_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  // Decoded straight from the state flop so reset drops Async_Flush at once.
  assign fifo_async_flush = (state_q == FLUSH);
  assign flushing         = (state_q != RUN);
  assign owner            = owner_q;
  assign overrun_cnt      = overrun_cnt_q;

endmodule

// File: tb/tb_sfifo36k_push_arbiter.sv
// Directed bench for sfifo36k_push_arbiter: arbitration, burst cap, Full gating,
// flush sequencing, overrun counter saturation and asynchronous reset.
module tb_sfifo36k_push_arbiter;
  localparam int W = 18;

  logic         clock0 = 1'b0;
  logic         reset_n = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         sw_flush = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1, fifo_overrun = 1'b0;
  logic [W-1:0] fifo_din;
  logic         fifo_push, fifo_async_flush, owner, flushing;
  logic [7:0]   overrun_cnt;

  int checks = 0;
  int errors = 0;

  sfifo36k_push_arbiter #(.WR_DATA_WIDTH(W), .MAX_BURST(8), .FLUSH_CYCLES(4)) dut (
    .clock0(clock0), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sw_flush(sw_flush), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_overrun(fifo_overrun), .fifo_din(fifo_din), .fifo_push(fifo_push),
    .fifo_async_flush(fifo_async_flush), .owner(owner), .flushing(flushing),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clock0 = ~clock0;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(posedge clock0);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clock0);
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL rst_push: got %b want 0", fifo_push); end
    checks++; if (fifo_din !== '0) begin errors++; $display("FAIL rst_din: got %h want 0", fifo_din); end
    checks++; if (fifo_async_flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", fifo_async_flush); end
    checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL rst_flushing: got %b want 0", flushing); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b want 0", owner); end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_ovr: got %0d want 0", overrun_cnt); end
  endtask

  // Both requesters saturated: 8 x req0, 8 x req1, 8 x req0, a push every cycle.
  task automatic test_round_robin();
    logic exp_sel;
    reset_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      req0_data = 18'h0A000 + W'(i);
      req1_data = 18'h1B000 + W'(i);
      exp_sel   = ((i / 8) % 2) == 1;
      #1;
      checks++; if (fifo_push !== 1'b1) begin errors++; $display("FAIL rr_push[%0d]: got %b want 1", i, fifo_push); end
      checks++; if (req0_ready !== !exp_sel) begin errors++; $display("FAIL rr_ready0[%0d]: got %b want %b", i, req0_ready, !exp_sel); end
      checks++; if (req1_ready !== exp_sel) begin errors++; $display("FAIL rr_ready1[%0d]: got %b want %b", i, req1_ready, exp_sel); end
      checks++; if (fifo_din !== (exp_sel ? req1_data : req0_data)) begin
        errors++; $display("FAIL rr_din[%0d]: got %h want %h", i, fifo_din, exp_sel ? req1_data : req0_data);
      end
      next_cycle();
    end
  endtask

  // The cap does not apply while the other requester is idle.
  task automatic test_solo_req1();
    req0_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req1_data = 18'h1C000 + W'(i);
      #1;
      checks++; if (req1_ready !== 1'b1 || fifo_push !== 1'b1) begin
        errors++; $display("FAIL solo_r1[%0d]: got ready1=%b push=%b want 1/1", i, req1_ready, fifo_push);
      end
      checks++; if (fifo_din !== req1_data) begin errors++; $display("FAIL solo_din[%0d]: got %h want %h", i, fifo_din, req1_data); end
      next_cycle();
    end
    req0_valid = 1'b1;
    req0_data  = 18'h0D00D;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL solo_switch: got ready0=%b ready1=%b want 1/0", req0_ready, req1_ready);
    end
    checks++; if (fifo_din !== 18'h0D00D) begin errors++; $display("FAIL solo_switch_din: got %h want 0d00d", fifo_din); end
    next_cycle();
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL solo_owner: got %b want 0", owner); end
  endtask

  // Full mid-burst freezes owner and run count; req0 then finishes its 8-word burst.
  task automatic test_full();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL full_pre[%0d]: got %b want 1", i, req0_ready); end
      next_cycle();
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (fifo_push !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL full_gate[%0d]: got push=%b r0=%b r1=%b want 0/0/0", i, fifo_push, req0_ready, req1_ready);
      end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL full_owner[%0d]: got %b want 0", i, owner); end
      next_cycle();
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req0_ready !== (i < 4) || req1_ready !== (i == 4)) begin
        errors++; $display("FAIL full_resume[%0d]: got r0=%b r1=%b want %b/%b", i, req0_ready, req1_ready, i < 4, i == 4);
      end
      next_cycle();
    end
  endtask

  task automatic test_overrun();
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    fifo_empty   = 1'b0;
    fifo_overrun = 1'b1;
    #1;
    checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL ovr_pre: got flushing=%b want 0", flushing); end
    next_cycle();
    fifo_overrun = 1'b0;
    req0_valid   = 1'b1;
    req1_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (fifo_async_flush !== 1'b1 || flushing !== 1'b1) begin
        errors++; $display("FAIL ovr_flush[%0d]: got async=%b flushing=%b want 1/1", i, fifo_async_flush, flushing);
      end
      checks++; if (fifo_push !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL ovr_gate[%0d]: got push=%b r0=%b r1=%b want 0/0/0", i, fifo_push, req0_ready, req1_ready);
      end
      checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cnt[%0d]: got %0d want 1", i, overrun_cnt); end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fifo_async_flush !== 1'b0 || flushing !== 1'b1 || fifo_push !== 1'b0) begin
        errors++; $display("FAIL ovr_wait[%0d]: got async=%b flushing=%b push=%b want 0/1/0", i, fifo_async_flush, flushing, fifo_push);
      end
      next_cycle();
    end
    fifo_empty = 1'b1;
    #1;
    checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL ovr_empty_edge: got flushing=%b want 1", flushing); end
    next_cycle();
    #1;
    checks++; if (flushing !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL ovr_restart: got flushing=%b r0=%b r1=%b want 0/1/0", flushing, req0_ready, req1_ready);
    end
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Transfer completes alongside sw_flush; re-request at flush_cnt=3 stretches flush to 7.
  task automatic test_sw_flush();
    req0_valid = 1'b1;
    req0_data  = 18'h2C0DE;
    sw_flush   = 1'b1;
    #1;
    checks++; if (fifo_push !== 1'b1 || fifo_din !== 18'h2C0DE) begin
      errors++; $display("FAIL swf_xfer: got push=%b din=%h want 1/2c0de", fifo_push, fifo_din);
    end
    next_cycle();
    req0_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sw_flush = (k == 2);
      #1;
      checks++; if (fifo_async_flush !== (k < 7) || flushing !== (k < 8)) begin
        errors++; $display("FAIL swf_seq[%0d]: got async=%b flushing=%b want %b/%b", k, fifo_async_flush, flushing, k < 7, k < 8);
      end
      next_cycle();
    end
    sw_flush = 1'b0;
    checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL swf_ovr: got %0d want 1", overrun_cnt); end
  endtask

  task automatic test_saturate();
    int t;
    for (int n = 2; n <= 300; n++) begin
      fifo_overrun = 1'b1;
      next_cycle();
      fifo_overrun = 1'b0;
      t = 0;
      while (flushing && t < 20) begin
        next_cycle();
        t++;
      end
      checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL sat_timeout[%0d]: still flushing after %0d cycles", n, t); end
      checks++; if (overrun_cnt !== ((n > 255) ? 8'd255 : 8'(n))) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", n, overrun_cnt, (n > 255) ? 255 : n);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    fifo_overrun = 1'b1;
    next_cycle();
    fifo_overrun = 1'b0;
    next_cycle();
    checks++; if (fifo_async_flush !== 1'b1) begin errors++; $display("FAIL rmf_pre: got async=%b want 1", fifo_async_flush); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (fifo_async_flush !== 1'b0 || flushing !== 1'b0) begin
      errors++; $display("FAIL rmf_async: got async=%b flushing=%b want 0/0", fifo_async_flush, flushing);
    end
    checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL rmf_ovr: got %0d want 0", overrun_cnt); end
    next_cycle();
    reset_n    = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1 || flushing !== 1'b0) begin
      errors++; $display("FAIL rmf_run: got r1=%b flushing=%b want 1/0", req1_ready, flushing);
    end
    next_cycle();
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_solo_req1();
    test_full();
    test_overrun();
    test_sw_flush();
    test_saturate();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
